// File: rtl/pe_arr_skew_feeder.sv
// ============================================================================
// Module   : pe_arr_skew_feeder
// Brief    : Diagonal skew feeder driving PE_ARR operands, fire enable and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_arr_skew_feeder #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [0:8*ROWS-1]   in_a,
    input  logic [0:8*COLS-1]   in_w,
    output logic [0:8*ROWS-1]   in_a_port,
    output logic [0:8*COLS-1]   in_w_port,
    output logic                fire,
    output logic                busy,
    output logic                done
);

    localparam int F  = ((ROWS > COLS) ? ROWS : COLS) - 1;
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam logic [CW-1:0] LAST_CNT = (F > 0) ? CW'(F - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic            accept;
    logic            advance;

    assign in_ready = (state == IDLE) || (state == STREAM);
    assign accept   = in_valid && in_ready;
    // With a single-lane array there is nothing to flush, so FLUSH never advances.
    assign advance  = accept || ((state == FLUSH) && (F != 0));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            flush_cnt <= '0;
            fire      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fire <= advance;
            done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (in_last) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                FLUSH: begin
                    if ((F == 0) || (flush_cnt == LAST_CNT)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane i is a chain of i+1 registers; during FLUSH zeros enter at the head.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        logic [7:0] pipe [0:i];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s <= i; s++) begin
                    pipe[s] <= 8'h00;
                end
            end else if (advance) begin
                pipe[0] <= accept ? in_a[8*i +: 8] : 8'h00;
                for (int s = 1; s <= i; s++) begin
                    pipe[s] <= pipe[s-1];
                end
            end
        end

        assign in_a_port[8*i +: 8] = pipe[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_w_lane
        logic [7:0] pipe [0:j];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s <= j; s++) begin
                    pipe[s] <= 8'h00;
                end
            end else if (advance) begin
                pipe[0] <= accept ? in_w[8*j +: 8] : 8'h00;
                for (int s = 1; s <= j; s++) begin
                    pipe[s] <= pipe[s-1];
                end
            end
        end

        assign in_w_port[8*j +: 8] = pipe[j];
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_arr_skew_feeder.sv
// ============================================================================
// Module   : tb_pe_arr_skew_feeder
// Brief    : Self-checking bench for pe_arr_skew_feeder against a history model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_arr_skew_feeder;

    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int F    = ((ROWS > COLS) ? ROWS : COLS) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_FLUSH  = 2;
    localparam int M_DONE   = 3;

    typedef logic [0:8*ROWS-1] va_t;
    typedef logic [0:8*COLS-1] vw_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_last = 1'b0;
    va_t  in_a = '0;
    vw_t  in_w = '0;
    va_t  in_a_port;
    vw_t  in_w_port;
    logic fire;
    logic busy;
    logic done;

    pe_arr_skew_feeder #(.ROWS(ROWS), .COLS(COLS)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_w      (in_w),
        .in_a_port (in_a_port),
        .in_w_port (in_w_port),
        .fire      (fire),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: every advance since reset, in order; port lane i shows entry n-1-i.
    int   mode;
    int   rem;
    va_t  ha[$];
    vw_t  hw[$];
    bit   e_fire;
    bit   e_done;
    int   job_len;
    bit   job_clean;
    int   fire_run;

    function automatic va_t exp_a();
        va_t v;
        va_t t;
        int  n;
        v = '0;
        n = ha.size();
        for (int i = 0; i < ROWS; i++) begin
            if (n - 1 - i >= 0) begin
                t = ha[n-1-i];
                v[8*i +: 8] = t[8*i +: 8];
            end
        end
        return v;
    endfunction

    function automatic vw_t exp_w();
        vw_t v;
        vw_t t;
        int  n;
        v = '0;
        n = hw.size();
        for (int j = 0; j < COLS; j++) begin
            if (n - 1 - j >= 0) begin
                t = hw[n-1-j];
                v[8*j +: 8] = t[8*j +: 8];
            end
        end
        return v;
    endfunction

    function automatic va_t rnd_a();
        va_t v;
        for (int i = 0; i < ROWS; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    function automatic vw_t rnd_w();
        vw_t v;
        for (int j = 0; j < COLS; j++) v[8*j +: 8] = 8'($urandom);
        return v;
    endfunction

    function automatic va_t pat_a(int k);
        va_t v;
        for (int i = 0; i < ROWS; i++) v[8*i +: 8] = 8'(16*k + i);
        return v;
    endfunction

    function automatic vw_t pat_w(int k);
        vw_t v;
        for (int j = 0; j < COLS; j++) v[8*j +: 8] = 8'(32*k + j);
        return v;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [8*ROWS-1:0] obs,
                           input logic [8*ROWS-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        rem = 0;
        ha.delete();
        hw.delete();
        e_fire = 1'b0;
        e_done = 1'b0;
        job_len = 0;
        job_clean = 1'b0;
        fire_run = 0;
    endtask

    task automatic check_outputs();
        chk_bit("in_ready", in_ready, (mode == M_IDLE) || (mode == M_STREAM));
        chk_bit("fire", fire, e_fire);
        chk_bit("done", done, e_done);
        chk_bit("busy", busy, mode != M_IDLE);
        chk_vec("in_a_port", in_a_port, exp_a());
        chk_vec("in_w_port", {{(8*(ROWS-COLS)){1'b0}}, in_w_port},
                {{(8*(ROWS-COLS)){1'b0}}, exp_w()});
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, check at edge+1.
    task automatic cyc(input logic v, input logic l, input va_t a, input vw_t w);
        bit rdy, acc, adv;
        in_valid = v;
        in_last  = l;
        in_a     = a;
        in_w     = w;
        rdy = (mode == M_IDLE) || (mode == M_STREAM);
        acc = v && rdy;
        adv = acc || (mode == M_FLUSH);
        @(posedge clk);
        if (adv) begin
            ha.push_back(acc ? a : '0);
            hw.push_back(acc ? w : '0);
        end
        e_fire = adv;
        e_done = 1'b0;
        case (mode)
            M_IDLE, M_STREAM: begin
                if (acc) begin
                    if (mode == M_IDLE) begin
                        job_len = 0;
                        job_clean = 1'b1;
                    end
                    job_len++;
                    if (l) begin
                        mode = M_FLUSH;
                        rem = F;
                    end else begin
                        mode = M_STREAM;
                    end
                end else if (mode == M_STREAM) begin
                    job_clean = 1'b0;
                end
            end
            M_FLUSH: begin
                rem--;
                if (rem == 0) begin
                    mode = M_DONE;
                    e_done = 1'b1;
                end
            end
            default: mode = M_IDLE;
        endcase
        #1;
        check_outputs();
        if (fire === 1'b1) fire_run++;
        else fire_run = 0;
        if (e_done && job_clean) chk_int("fire_run_len", fire_run, job_len + F);
    endtask

    task automatic drain();
        for (int k = 0; k < 4*F + 10 && mode != M_IDLE; k++) begin
            cyc(1'b0, 1'($urandom), rnd_a(), rnd_w());
        end
        cyc(1'b0, 1'b0, rnd_a(), rnd_w());
    endtask

    task automatic run_job(input int n, input int bub_after, input int bub_len);
        for (int k = 1; k <= n; k++) begin
            cyc(1'b1, k == n, pat_a(k), pat_w(k));
            if (k == bub_after) begin
                for (int b = 0; b < bub_len; b++) cyc(1'b0, 1'($urandom), rnd_a(), rnd_w());
            end
        end
        drain();
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset held while inputs toggle randomly.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom);
            in_last  = 1'($urandom);
            in_a     = rnd_a();
            in_w     = rnd_w();
            @(posedge clk);
            #1;
            check_outputs();
        end
        rstn = 1'b1;
        in_valid = 1'b0;
        #1;
        check_outputs();

        run_job(4, 0, 0);
        run_job(4, 2, 2);

        // in_valid held high through FLUSH/DONE; next beat lands in the IDLE cycle.
        cyc(1'b1, 1'b0, pat_a(1), pat_w(1));
        cyc(1'b1, 1'b1, pat_a(2), pat_w(2));
        for (int k = 0; k < F + 1; k++) cyc(1'b1, 1'b1, rnd_a(), rnd_w());
        chk_int("idle_before_next_job", mode, M_IDLE);
        cyc(1'b1, 1'b1, pat_a(3), pat_w(3));
        chk_int("next_job_accepted", mode, M_FLUSH);
        drain();

        run_job(1, 0, 0);

        // Reset during FLUSH discards the job, then a bubbled job runs cleanly.
        cyc(1'b1, 1'b0, pat_a(1), pat_w(1));
        cyc(1'b1, 1'b0, pat_a(2), pat_w(2));
        cyc(1'b1, 1'b1, pat_a(3), pat_w(3));
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, rnd_a(), rnd_w());
        reset_pulse();
        cyc(1'b0, 1'b0, rnd_a(), rnd_w());
        run_job(4, 2, 2);

        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rnd_a(), rnd_w());
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
